cr_clint_busif: RTL and testbench

CR_CLINT_BUSIF -- requirements
Module: cr_clint_busif

---
 rtl/cr_clint_pkg.sv | 24 ++
 rtl/cr_clint_busif_dec.sv | 21 ++
 rtl/cr_clint_busif.sv | 72 +++++++
 tb/tb_cr_clint_busif.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cr_clint_pkg.sv
// cr_clint_pkg: shared register offsets, AHB encodings, select indices and bus FSM states for the CLINT.
package cr_clint_pkg;
  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam int SEL_W        = 5;
  localparam int SEL_MSIP     = 0;
  localparam int SEL_CMP_LO   = 1;
  localparam int SEL_CMP_HI   = 2;
  localparam int SEL_MTIME_LO = 3;
  localparam int SEL_MTIME_HI = 4;
  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;
endpackage

// File: rtl/cr_clint_busif_dec.sv
// cr_clint_busif_dec: decodes an address phase into a one-hot register select and an error flag.
module cr_clint_busif_dec
  import cr_clint_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter bit ERR_ON_RO_WR = 1'b0
) (
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  output logic [SEL_W-1:0]  sel,
  output logic              err
);
  always_comb begin
    sel = {haddr == ADDR_W'(MTIME_HI_OFF), haddr == ADDR_W'(MTIME_LO_OFF),
           haddr == ADDR_W'(MTIMECMP_HI_OFF), haddr == ADDR_W'(MTIMECMP_LO_OFF),
           haddr == ADDR_W'(MSIP_OFF)};
    err = ~|sel | (hsize != HSIZE_WORD) | (|haddr[1:0])
        | (ERR_ON_RO_WR & hwrite & (sel[SEL_MTIME_LO] | sel[SEL_MTIME_HI]));
  end
endmodule

// File: rtl/cr_clint_busif.sv
// cr_clint_busif: AHB-Lite slave front end of the CLINT; zero-wait OKAY transfers, two-cycle ERROR responses.
module cr_clint_busif
  import cr_clint_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter bit ERR_ON_RO_WR = 1'b0
) (
  input  logic              clint_clk,
  input  logic              cpurst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              busif_regs_msip_sel,
  output logic              busif_regs_mtimecmp_lo_sel,
  output logic              busif_regs_mtimecmp_hi_sel,
  output logic [31:0]       busif_regs_wdata,
  output logic              busif_regs_write_vld,
  input  logic [31:0]       msip_value,
  input  logic [31:0]       mtimecmp_lo_value,
  input  logic [31:0]       mtimecmp_hi_value,
  input  logic [31:0]       mtime_lo_value,
  input  logic [31:0]       mtime_hi_value
);
  logic             accept, dec_err, write_q, err_q, good, wr;
  logic [SEL_W-1:0] dec_sel, sel_q;
  state_t           state;
  assign accept = hsel & hready & htrans[1];
  cr_clint_busif_dec #(.ADDR_W(ADDR_W), .ERR_ON_RO_WR(ERR_ON_RO_WR)) u_dec (
    .haddr  (haddr),
    .hsize  (hsize),
    .hwrite (hwrite),
    .sel    (dec_sel),
    .err    (dec_err)
  );
  // Phase registers live for exactly one data-phase cycle; errored transfers latch no select.
  always_ff @(posedge clint_clk or posedge cpurst) begin
    if (cpurst) begin
      state   <= ST_DATA;
      sel_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= accept & ~dec_err ? dec_sel : '0;
      write_q <= accept & hwrite;
      err_q   <= accept & dec_err;
      state   <= state == ST_ERR1 ? ST_ERR2 : accept & dec_err ? ST_ERR1 : ST_DATA;
    end
  end
  assign hreadyout = state != ST_ERR1;
  assign hresp     = state != ST_DATA;
  assign good      = state == ST_DATA & ~err_q;
  assign wr        = good & write_q;
  assign busif_regs_msip_sel        = wr & sel_q[SEL_MSIP];
  assign busif_regs_mtimecmp_lo_sel = wr & sel_q[SEL_CMP_LO];
  assign busif_regs_mtimecmp_hi_sel = wr & sel_q[SEL_CMP_HI];
  assign busif_regs_write_vld       = wr & |sel_q[SEL_CMP_HI:SEL_MSIP];
  assign busif_regs_wdata           = hwdata;
  assign hrdata = ~good | write_q  ? '0
                : sel_q[SEL_MSIP]     ? msip_value
                : sel_q[SEL_CMP_LO]   ? mtimecmp_lo_value
                : sel_q[SEL_CMP_HI]   ? mtimecmp_hi_value
                : sel_q[SEL_MTIME_LO] ? mtime_lo_value
                : sel_q[SEL_MTIME_HI] ? mtime_hi_value
                : '0;
endmodule

// File: tb/tb_cr_clint_busif.sv
// tb_cr_clint_busif: vector table, directed corner sequences and a randomized model check of cr_clint_busif.
module tb_cr_clint_busif;
  import cr_clint_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
  logic [15:0] haddr = '0;
  logic [1:0] htrans = '0;
  logic [2:0] hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic [31:0] vals [5];
  logic rdy0, resp0, ms0, lo0, hi0, vld0, rdy1, resp1, ms1, lo1, hi1, vld1;
  logic [31:0] rd0, wd0, rd1, wd1;
  wire [5:0] f0 = {rdy0, resp0, vld0, ms0, lo0, hi0};
  wire [5:0] f1 = {rdy1, resp1, vld1, ms1, lo1, hi1};
  int checks = 0, failures = 0;
  int errcnt = 0, p_idx = -1;
  logic p_valid = 1'b0, p_err = 1'b0, p_wr = 1'b0;

  cr_clint_busif dut0 (
    .clint_clk(clk), .cpurst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(rdy0), .hresp(resp0), .hrdata(rd0),
    .busif_regs_msip_sel(ms0), .busif_regs_mtimecmp_lo_sel(lo0), .busif_regs_mtimecmp_hi_sel(hi0),
    .busif_regs_wdata(wd0), .busif_regs_write_vld(vld0), .msip_value(vals[0]),
    .mtimecmp_lo_value(vals[1]), .mtimecmp_hi_value(vals[2]), .mtime_lo_value(vals[3]),
    .mtime_hi_value(vals[4]));

  cr_clint_busif #(.ERR_ON_RO_WR(1'b1)) dut1 (
    .clint_clk(clk), .cpurst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(rdy1), .hresp(resp1), .hrdata(rd1),
    .busif_regs_msip_sel(ms1), .busif_regs_mtimecmp_lo_sel(lo1), .busif_regs_mtimecmp_hi_sel(hi1),
    .busif_regs_wdata(wd1), .busif_regs_write_vld(vld1), .msip_value(vals[0]),
    .mtimecmp_lo_value(vals[1]), .mtimecmp_hi_value(vals[2]), .mtime_lo_value(vals[3]),
    .mtime_hi_value(vals[4]));

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [2:0]  s;
    logic [31:0] d;
    logic        e;
    logic [5:0]  f;
    logic [31:0] r;
  } vec_t;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", n, a, e);
    end
  endtask

  task automatic chkf(string n, logic [5:0] a, logic [5:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s flags actual=%b required=%b (rdy,resp,vld,msip,lo,hi)", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(logic [15:0] a, logic w, logic [2:0] s);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = w; hsize = s; hready = 1'b1;
  endtask

  task automatic idle_phase();
    hsel = 1'b0; htrans = HTRANS_IDLE; hready = 1'b1;
  endtask

  function automatic int reg_idx(logic [15:0] a);
    case (a)
      16'h0000: return 0;
      16'h4000: return 1;
      16'h4004: return 2;
      16'hBFF8: return 3;
      16'hBFFC: return 4;
      default:  return -1;
    endcase
  endfunction

  initial begin
    vec_t tbl [14];
    logic [15:0] addrs [8];
    logic e1, acc, good, e_vld;
    logic [2:0] e_sel;
    logic [31:0] e_rd;
    int idx;
    vals = '{32'h0000_0001, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'hDEAD_BEEF};
    addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0008, 16'h4002, 16'h8000};
    tbl[0]  = '{16'h4000, 1'b1, 3'b010, 32'h1234_5678, 1'b0, 6'b101010, 32'h0};
    tbl[1]  = '{16'hBFFC, 1'b0, 3'b010, 32'h0,         1'b0, 6'b100000, 32'hDEAD_BEEF};
    tbl[2]  = '{16'h0008, 1'b0, 3'b010, 32'h0,         1'b1, 6'b000000, 32'h0};
    tbl[3]  = '{16'h0000, 1'b1, 3'b000, 32'h55,        1'b1, 6'b000000, 32'h0};
    tbl[4]  = '{16'hBFF8, 1'b1, 3'b010, 32'h99,        1'b0, 6'b100000, 32'h0};
    tbl[5]  = '{16'h0000, 1'b0, 3'b010, 32'h0,         1'b0, 6'b100000, 32'h0000_0001};
    tbl[6]  = '{16'h4004, 1'b0, 3'b010, 32'h0,         1'b0, 6'b100000, 32'h3333_4444};
    tbl[7]  = '{16'h0002, 1'b1, 3'b010, 32'h7,         1'b1, 6'b000000, 32'h0};
    tbl[8]  = '{16'h4004, 1'b1, 3'b010, 32'hFFFF_FFFF, 1'b0, 6'b101001, 32'h0};
    tbl[9]  = '{16'hBFF8, 1'b0, 3'b010, 32'h0,         1'b0, 6'b100000, 32'h5555_6666};
    tbl[10] = '{16'h4001, 1'b0, 3'b000, 32'h0,         1'b1, 6'b000000, 32'h0};
    tbl[11] = '{16'h0000, 1'b1, 3'b011, 32'h1,         1'b1, 6'b000000, 32'h0};
    tbl[12] = '{16'h0000, 1'b1, 3'b010, 32'h1,         1'b0, 6'b101100, 32'h0};
    tbl[13] = '{16'hBFFC, 1'b1, 3'b010, 32'hABCD,      1'b0, 6'b100000, 32'h0};

    // Reset: an address phase presented during reset must leave no trace.
    #1 addr_phase(16'h4000, 1'b1, 3'b010);
    #11;
    chkf("reset0", f0, 6'b100000);
    chk("reset0_rdata", rd0, 32'h0);
    chkf("reset1", f1, 6'b100000);
    tick(); tick();
    rst = 1'b0; idle_phase();
    tick(); #2;
    chkf("post_reset", f0, 6'b100000);

    foreach (tbl[i]) begin
      e1 = tbl[i].e | (tbl[i].w & (tbl[i].a == 16'hBFF8 | tbl[i].a == 16'hBFFC));
      tick(); addr_phase(tbl[i].a, tbl[i].w, tbl[i].s);
      tick(); idle_phase(); hwdata = tbl[i].d; #2;
      chkf($sformatf("v%0d_dp", i), f0, tbl[i].e ? 6'b010000 : tbl[i].f);
      chk($sformatf("v%0d_rdata", i), rd0, tbl[i].e ? 32'h0 : tbl[i].r);
      chkf($sformatf("v%0d_dp_ro", i), f1, e1 ? 6'b010000 : tbl[i].f);
      if (!tbl[i].e && tbl[i].w) chk($sformatf("v%0d_wdata", i), wd0, tbl[i].d);
      if (tbl[i].e | e1) begin
        tick(); #2;
        chkf($sformatf("v%0d_err2", i), f0, tbl[i].e ? 6'b110000 : 6'b100000);
        chkf($sformatf("v%0d_err2_ro", i), f1, e1 ? 6'b110000 : 6'b100000);
        tick(); #2;
        chkf($sformatf("v%0d_after", i), f0, 6'b100000);
        chkf($sformatf("v%0d_after_ro", i), f1, 6'b100000);
      end
    end

    // Back-to-back write, read, write.
    tick(); addr_phase(16'h0000, 1'b1, 3'b010);
    tick(); addr_phase(16'h0000, 1'b0, 3'b010); hwdata = 32'h1; #2;
    chkf("b2b_w1", f0, 6'b101100);
    chk("b2b_w1_wdata", wd0, 32'h1);
    tick(); addr_phase(16'h4004, 1'b1, 3'b010); hwdata = 32'h0; #2;
    chkf("b2b_r", f0, 6'b100000);
    chk("b2b_r_rdata", rd0, vals[0]);
    tick(); idle_phase(); hwdata = 32'hFFFF_FFFF; #2;
    chkf("b2b_w2", f0, 6'b101001);
    chk("b2b_w2_wdata", wd0, 32'hFFFF_FFFF);
    tick(); #2;
    chkf("b2b_idle", f0, 6'b100000);

    // Address phases that must not be accepted.
    tick(); addr_phase(16'h0000, 1'b1, 3'b010); hready = 1'b0;
    tick(); idle_phase(); hwdata = 32'h77; #2;
    chkf("hready_low", f0, 6'b100000);
    tick(); addr_phase(16'h4000, 1'b1, 3'b010); htrans = HTRANS_BUSY;
    tick(); idle_phase(); #2;
    chkf("busy", f0, 6'b100000);
    tick(); addr_phase(16'h4000, 1'b1, 3'b010); hsel = 1'b0;
    tick(); idle_phase(); #2;
    chkf("hsel_low", f0, 6'b100000);

    // New errored accept in ERR2 restarts the error, then a good read accepted in ERR2.
    tick(); addr_phase(16'h0008, 1'b0, 3'b010);
    tick(); idle_phase(); hready = 1'b0; #2;
    chkf("ee_err1a", f0, 6'b010000);
    tick(); addr_phase(16'h0003, 1'b0, 3'b010); #2;
    chkf("ee_err2a", f0, 6'b110000);
    tick(); idle_phase(); hready = 1'b0; #2;
    chkf("ee_err1b", f0, 6'b010000);
    tick(); addr_phase(16'h0000, 1'b0, 3'b010); #2;
    chkf("ee_err2b", f0, 6'b110000);
    tick(); idle_phase(); #2;
    chkf("ee_good", f0, 6'b100000);
    chk("ee_good_rdata", rd0, vals[0]);

    // Reset in ERR1 aborts immediately; next write is normal.
    tick(); addr_phase(16'h0008, 1'b1, 3'b010);
    tick(); idle_phase(); #2;
    chkf("rst_err1", f0, 6'b010000);
    #1 rst = 1'b1;
    #1 chkf("rst_now", f0, 6'b100000);
    chk("rst_now_rdata", rd0, 32'h0);
    tick(); tick(); rst = 1'b0;
    tick(); addr_phase(16'h4000, 1'b1, 3'b010);
    tick(); idle_phase(); hwdata = 32'hAAAA_5555; #2;
    chkf("rst_after_w", f0, 6'b101010);
    chk("rst_after_wdata", wd0, 32'hAAAA_5555);

    // Randomized traffic against a transfer-level model.
    errcnt = 0; p_valid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      tick();
      hready = errcnt == 2 ? 1'b0 : errcnt == 1 ? 1'b1 : ($urandom_range(0, 7) != 0);
      hsel   = $urandom_range(0, 3) != 0;
      htrans = 2'($urandom);
      hwrite = 1'($urandom);
      hsize  = $urandom_range(0, 4) == 0 ? 3'($urandom) : 3'b010;
      haddr  = $urandom_range(0, 9) == 0 ? 16'($urandom) : addrs[$urandom_range(0, 7)];
      hwdata = $urandom;
      for (int k = 0; k < 5; k++) vals[k] = $urandom;
      #2;
      good  = errcnt == 0 && p_valid && !p_err;
      e_vld = good && p_wr && p_idx <= 2;
      e_sel = e_vld ? 3'b100 >> p_idx : 3'b000;
      e_rd  = good && !p_wr ? vals[p_idx] : 32'h0;
      chkf($sformatf("rnd%0d", n), f0, {errcnt != 2, errcnt != 0, e_vld, e_sel});
      chk($sformatf("rnd%0d_rdata", n), rd0, e_rd);
      if (e_vld) chk($sformatf("rnd%0d_wdata", n), wd0, hwdata);
      acc = hsel && hready && htrans[1];
      idx = reg_idx(haddr);
      p_err   = idx < 0 || hsize != 3'b010 || haddr[1:0] != 2'b00;
      errcnt  = errcnt == 2 ? 1 : (acc && p_err) ? 2 : 0;
      p_valid = acc;
      p_wr    = hwrite;
      p_idx   = idx;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
